// File: rtl/spi_regif_pkg.sv
// Shared constants and state encoding for the SPI register-access slave.
package spi_regif_pkg;

  localparam logic CMD_WR = 1'b0;
  localparam logic CMD_RD = 1'b1;

  localparam int unsigned FRAME_BITS = 16;
  localparam int unsigned ADDR_W     = 7;
  localparam int unsigned DATA_W     = 8;
  localparam int unsigned HDR_BITS   = FRAME_BITS - DATA_W;
  localparam int unsigned CNT_W      = 5;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StCmdAddr = 3'd1,
    StWData   = 3'd2,
    StRData   = 3'd3,
    StWaitCs  = 3'd4
  } state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchronizer with rise/fall detection on the last two stages.
module spi_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RESET_VAL   = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_rise,
  output logic o_fall
);

  // One extra stage beyond the synchronizer holds the previous settled value.
  logic [SYNC_STAGES:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= {(SYNC_STAGES + 1){RESET_VAL}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-1:0], i_d};
    end
  end

  assign o_rise = r_sync[SYNC_STAGES-1] & ~r_sync[SYNC_STAGES];
  assign o_fall = ~r_sync[SYNC_STAGES-1] & r_sync[SYNC_STAGES];

endmodule

// File: rtl/spi_slave_regif.sv
// SPI mode-0 slave terminating 16-bit {cmd, addr, data} register frames.
// Optional SPI_SLAVE_MISO_TRISTATE_EN adds a miso_oe output for shared miso lines.
module spi_slave_regif
  import spi_regif_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned MIN_HALF_PERIOD = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sck,
  input  logic              csn,
  input  logic              mosi,
  output logic              miso,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              frame_err
`ifdef SPI_SLAVE_MISO_TRISTATE_EN
  ,
  output logic              miso_oe
`endif
);

  logic w_sck_rise, w_sck_fall, w_csn_rise, w_csn_fall, w_mosi;
  logic [DATA_W-1:0] w_rx_next;

  state_e              r_state;
  logic [CNT_W-1:0]    r_bit_cnt;
  logic [DATA_W-2:0]   r_rx;
  logic [DATA_W-1:0]   r_tx;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [DATA_W-1:0]   r_wr_data;
  logic [ADDR_W-1:0]   r_rd_addr;
  logic                r_wr_en, r_rd_en, r_frame_err, r_miso, r_ld_pend, r_miso_oe;
  logic [SYNC_STAGES-1:0] r_mosi_sync;

  spi_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES),
    .RESET_VAL  (1'b0)
  ) u_sck_sync (
    .i_clk  (clk),
    .i_rst_n(reset),
    .i_d    (sck),
    .o_rise (w_sck_rise),
    .o_fall (w_sck_fall)
  );

  spi_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES),
    .RESET_VAL  (1'b1)
  ) u_csn_sync (
    .i_clk  (clk),
    .i_rst_n(reset),
    .i_d    (csn),
    .o_rise (w_csn_rise),
    .o_fall (w_csn_fall)
  );

  // mosi needs no edge detect; same depth keeps it aligned with the sck edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mosi_sync <= '0;
    end else begin
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
    end
  end

  assign w_mosi    = r_mosi_sync[SYNC_STAGES-1];
  assign w_rx_next = {r_rx, w_mosi};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= StIdle;
      r_bit_cnt   <= '0;
      r_rx        <= '0;
      r_tx        <= '0;
      r_addr      <= '0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_rd_addr   <= '0;
      r_wr_en     <= 1'b0;
      r_rd_en     <= 1'b0;
      r_frame_err <= 1'b0;
      r_miso      <= 1'b0;
      r_ld_pend   <= 1'b0;
      r_miso_oe   <= 1'b0;
    end else begin
      r_wr_en     <= 1'b0;
      r_rd_en     <= 1'b0;
      r_frame_err <= 1'b0;
      if (r_ld_pend) begin
        r_tx      <= rd_data;
        r_ld_pend <= 1'b0;
      end
      if (w_csn_fall) begin
        r_state   <= StCmdAddr;
        r_bit_cnt <= '0;
        r_rx      <= '0;
        r_miso    <= 1'b0;
        r_miso_oe <= 1'b0;
        if (r_state != StIdle) r_frame_err <= 1'b1;
      end else if (w_csn_rise) begin
        if (r_state == StCmdAddr || r_state == StWData || r_state == StRData) begin
          r_frame_err <= 1'b1;
        end
        r_state   <= StIdle;
        r_miso    <= 1'b0;
        r_miso_oe <= 1'b0;
      end else begin
        unique case (r_state)
          StCmdAddr: begin
            if (w_sck_rise) begin
              r_rx      <= w_rx_next[DATA_W-2:0];
              r_bit_cnt <= r_bit_cnt + 1'b1;
              if (r_bit_cnt == CNT_W'(HDR_BITS - 1)) begin
                r_addr <= w_rx_next[ADDR_W-1:0];
                if (w_rx_next[DATA_W-1] == CMD_RD) begin
                  r_rd_en   <= 1'b1;
                  r_rd_addr <= w_rx_next[ADDR_W-1:0];
                  r_ld_pend <= 1'b1;
                  r_state   <= StRData;
                end else begin
                  r_state <= StWData;
                end
              end
            end
          end
          StRData: begin
            if (w_sck_fall) begin
              r_miso    <= r_tx[DATA_W-1];
              r_tx      <= {r_tx[DATA_W-2:0], 1'b0};
              r_miso_oe <= 1'b1;
            end
            if (w_sck_rise) begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
              if (r_bit_cnt == CNT_W'(FRAME_BITS - 1)) r_state <= StWaitCs;
            end
          end
          StWData: begin
            if (w_sck_rise) begin
              r_rx      <= w_rx_next[DATA_W-2:0];
              r_bit_cnt <= r_bit_cnt + 1'b1;
              if (r_bit_cnt == CNT_W'(FRAME_BITS - 1)) begin
                r_wr_en   <= 1'b1;
                r_wr_addr <= r_addr;
                r_wr_data <= w_rx_next;
                r_state   <= StWaitCs;
              end
            end
          end
          StIdle, StWaitCs: ;
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  assign miso      = r_miso;
  assign wr_en     = r_wr_en;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;
  assign rd_en     = r_rd_en;
  assign rd_addr   = r_rd_addr;
  assign frame_err = r_frame_err;

`ifdef SPI_SLAVE_MISO_TRISTATE_EN
  assign miso_oe = r_miso_oe;
`else
  logic w_unused_oe;
  assign w_unused_oe = r_miso_oe;
`endif

`ifndef SYNTHESIS
  // Clocks since the last synchronized sck edge, saturating.
  logic [7:0] r_hp_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hp_cnt <= '1;
    end else if (w_sck_rise || w_sck_fall) begin
      r_hp_cnt <= '0;
    end else if (r_hp_cnt != '1) begin
      r_hp_cnt <= r_hp_cnt + 1'b1;
    end
  end

  a_half_period: assert property (@(posedge clk) disable iff (!reset)
    (w_sck_rise || w_sck_fall) |-> (r_hp_cnt >= 8'(MIN_HALF_PERIOD - 1)));

  a_strobe_excl: assert property (@(posedge clk) disable iff (!reset)
    !(r_wr_en && r_rd_en));
`endif

endmodule
